// File: rtl/serial_word_packer.sv
// Byte-to-word packer: gathers BYTES_PER_WORD received bytes into one RAM word,
// emits it with an auto-incrementing (wrapping) address and drops stale partial words.
module serial_word_packer #(
    parameter int unsigned BYTES_PER_WORD = 3,
    parameter int unsigned DEPTH          = 1024,
    parameter int unsigned ADDR_WIDTH     = 10,
    parameter int unsigned MSB_FIRST      = 0,
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rx_valid,
    input  logic [7:0]                    rx_data,
    input  logic                          clear,
    output logic                          word_valid,
    output logic [8*BYTES_PER_WORD-1:0]   word_data,
    output logic [ADDR_WIDTH-1:0]         word_addr,
    output logic                          frame_done,
    output logic                          timeout_err
);

    localparam int unsigned W  = 8 * BYTES_PER_WORD;
    localparam int unsigned PW = $clog2(W);
    localparam int unsigned CW = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam int unsigned TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [CW-1:0]         LAST_SLOT  = CW'(BYTES_PER_WORD - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [TW-1:0]         TIMER_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, COLLECT, EMIT} state_t;

    state_t                 state;
    logic [CW-1:0]          count;
    logic [CW-1:0]          slot;
    logic [TW-1:0]          timer;
    logic [W-1:0]           asm_q;
    logic [W-1:0]           asm_next;
    logic [PW-1:0]          byte_pos;
    logic [ADDR_WIDTH-1:0]  addr_next;

    always_comb begin
        // A byte arriving outside COLLECT (IDLE or EMIT) always starts a fresh word.
        slot     = (state == COLLECT) ? count : '0;
        byte_pos = (MSB_FIRST != 0) ? PW'(W - 8 - 8 * 32'(slot)) : PW'(8 * 32'(slot));
        asm_next = (slot == '0) ? '0 : asm_q;
        asm_next[byte_pos +: 8] = rx_data;

        if (clear)
            addr_next = '0;
        else if (state == EMIT)
            addr_next = (word_addr == LAST_ADDR) ? '0 : word_addr + 1'b1;
        else
            addr_next = word_addr;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            count       <= '0;
            timer       <= '0;
            asm_q       <= '0;
            word_valid  <= 1'b0;
            word_data   <= '0;
            word_addr   <= '0;
            frame_done  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            word_valid  <= 1'b0;
            frame_done  <= 1'b0;
            timeout_err <= 1'b0;
            word_addr   <= addr_next;

            if (clear) begin
                state <= IDLE;
                count <= '0;
                timer <= '0;
                asm_q <= '0;
            end else if (rx_valid) begin
                timer <= '0;
                if (slot == LAST_SLOT) begin
                    // frame_done uses addr_next so a back-to-back EMIT sees the post-increment address.
                    word_data  <= asm_next;
                    word_valid <= 1'b1;
                    frame_done <= (addr_next == LAST_ADDR);
                    state      <= EMIT;
                    count      <= '0;
                    asm_q      <= '0;
                end else begin
                    asm_q <= asm_next;
                    count <= slot + 1'b1;
                    state <= COLLECT;
                end
            end else if (state == COLLECT) begin
                if (TIMEOUT_CYCLES != 0 && timer == TIMER_LAST) begin
                    timeout_err <= 1'b1;
                    state       <= IDLE;
                    count       <= '0;
                    timer       <= '0;
                    asm_q       <= '0;
                end else if (TIMEOUT_CYCLES != 0) begin
                    timer <= timer + 1'b1;
                end
            end else begin
                state <= IDLE;
                timer <= '0;
            end
        end
    end

endmodule
